fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and load-use hazard unit for the pipelined RV32I core; next generation of the fixed two-source forwarding unit.
- Keeps its own shift-register scoreboard of the destination info of in-flight instructions past EX (stage 1 = MEM, stage 2 = WB, up to DEPTH stages).
- Selects forwarded operand data for the EX instruction with youngest-wins priority.
- Raises a stall request when a needed load result is not yet available.

---
 rtl/fwd_hazard_unit.sv | 131 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit with a shift-register scoreboard of in-flight destinations.
// Optional performance counters are enabled by defining FWD_HAZARD_PERF_EN.
module fwd_hazard_unit #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 2,
    parameter int LOAD_READY = 2,
    parameter int RBITS      = 5,
    localparam int SELW      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_in,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic                  ex_load_regfile,
    input  logic                  ex_is_load,
    input  logic [RBITS-1:0]      ex_rd,
    input  logic [RBITS-1:0]      ex_rs1,
    input  logic [RBITS-1:0]      ex_rs2,
    input  logic                  ex_uses_rs1,
    input  logic                  ex_uses_rs2,
    input  logic [XLEN-1:0]       rf_rs1,
    input  logic [XLEN-1:0]       rf_rs2,
    input  logic [DEPTH*XLEN-1:0] stage_wdata,
    output logic [XLEN-1:0]       opnd1,
    output logic [XLEN-1:0]       opnd2,
    output logic [SELW-1:0]       fwd1_sel,
    output logic [SELW-1:0]       fwd2_sel,
    output logic                  hazard_stall
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_fwd_cnt
`endif
);

    // Scoreboard entry k: index 1 is the instruction that just left EX.
    logic             sb_vld [1:DEPTH];
    logic             sb_wr  [1:DEPTH];
    logic             sb_ld  [1:DEPTH];
    logic [RBITS-1:0] sb_rd  [1:DEPTH];

    int   win1, win2;
    logic ld1, ld2;
    logic bubble;

    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        win1  = 0;
        win2  = 0;
        ld1   = 1'b0;
        ld2   = 1'b0;
        opnd1 = rf_rs1;
        opnd2 = rf_rs2;
        for (int k = DEPTH; k >= 1; k--) begin
            if (sb_vld[k] && sb_wr[k] && (sb_rd[k] != '0)) begin
                if (ex_valid && ex_uses_rs1 && (sb_rd[k] == ex_rs1)) begin
                    win1  = k;
                    ld1   = sb_ld[k];
                    opnd1 = stage_wdata[(k-1)*XLEN +: XLEN];
                end
                if (ex_valid && ex_uses_rs2 && (sb_rd[k] == ex_rs2)) begin
                    win2  = k;
                    ld2   = sb_ld[k];
                    opnd2 = stage_wdata[(k-1)*XLEN +: XLEN];
                end
            end
        end
        fwd1_sel     = SELW'(win1);
        fwd2_sel     = SELW'(win2);
        hazard_stall = !flush &&
                       (((win1 != 0) && ld1 && (win1 < LOAD_READY)) ||
                        ((win2 != 0) && ld2 && (win2 < LOAD_READY)));
        bubble       = hazard_stall || flush || !ex_valid;
    end

    // Scoreboard advance: hold on external freeze, otherwise shift toward WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                sb_vld[k] <= 1'b0;
                sb_wr[k]  <= 1'b0;
                sb_ld[k]  <= 1'b0;
                sb_rd[k]  <= '0;
            end
        end else if (!stall_in) begin
            for (int k = 2; k <= DEPTH; k++) begin
                sb_vld[k] <= sb_vld[k-1];
                sb_wr[k]  <= sb_wr[k-1];
                sb_ld[k]  <= sb_ld[k-1];
                sb_rd[k]  <= sb_rd[k-1];
            end
            if (bubble) begin
                sb_vld[1] <= 1'b0;
                sb_wr[1]  <= 1'b0;
                sb_ld[1]  <= 1'b0;
                sb_rd[1]  <= '0;
            end else begin
                sb_vld[1] <= 1'b1;
                sb_wr[1]  <= ex_load_regfile;
                sb_ld[1]  <= ex_is_load;
                sb_rd[1]  <= ex_rd;
            end
        end
    end

`ifdef FWD_HAZARD_PERF_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + {31'd0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    logic [1:0] fwd_inc;
    assign fwd_inc = {1'b0, (fwd1_sel != '0)} + {1'b0, (fwd2_sel != '0)};

    // Counters only advance on cycles where the pipeline is not frozen externally.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else if (!stall_in) begin
            if (hazard_stall)
                perf_stall_cnt <= sat_add(perf_stall_cnt, 2'd1);
            else
                perf_fwd_cnt   <= sat_add(perf_fwd_cnt, fwd_inc);
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed testbench for fwd_hazard_unit (DEPTH=2, LOAD_READY=2); perf checks when FWD_HAZARD_PERF_EN is defined.
module tb_fwd_hazard_unit;
    localparam int XLEN = 32;
    localparam int DEPTH = 2;
    localparam int LR = 2;
    localparam int RBITS = 5;
    localparam int SELW = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst, stall_in, flush, ex_valid, ex_load_regfile, ex_is_load;
    logic [RBITS-1:0] ex_rd, ex_rs1, ex_rs2;
    logic ex_uses_rs1, ex_uses_rs2;
    logic [XLEN-1:0] rf_rs1, rf_rs2;
    logic [DEPTH*XLEN-1:0] stage_wdata;
    logic [XLEN-1:0] opnd1, opnd2;
    logic [SELW-1:0] fwd1_sel, fwd2_sel;
    logic hazard_stall;
`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt, perf_fwd_cnt;
`endif

    int errors = 0;
    int checks = 0;

    fwd_hazard_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .LOAD_READY(LR), .RBITS(RBITS)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
        .ex_valid(ex_valid), .ex_load_regfile(ex_load_regfile), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_uses_rs1(ex_uses_rs1), .ex_uses_rs2(ex_uses_rs2),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .stage_wdata(stage_wdata),
        .opnd1(opnd1), .opnd2(opnd2), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
        .hazard_stall(hazard_stall)
`ifdef FWD_HAZARD_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        stall_in = 0; flush = 0; ex_valid = 0; ex_load_regfile = 0; ex_is_load = 0;
        ex_rd = 0; ex_rs1 = 0; ex_rs2 = 0; ex_uses_rs1 = 0; ex_uses_rs2 = 0;
        rf_rs1 = 32'h1111_0001; rf_rs2 = 32'h2222_0002; stage_wdata = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    // EX instruction writing rd; is_ld marks a load.
    task automatic ex_writer(input logic [RBITS-1:0] rd, input logic is_ld);
        ex_valid = 1; ex_load_regfile = 1; ex_is_load = is_ld; ex_rd = rd;
        ex_uses_rs1 = 0; ex_uses_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0;
    endtask

    // EX instruction reading sources and not writing any register.
    task automatic ex_reader(input logic [RBITS-1:0] rs1, input logic u1,
                             input logic [RBITS-1:0] rs2, input logic u2);
        ex_valid = 1; ex_load_regfile = 0; ex_is_load = 0; ex_rd = 0;
        ex_rs1 = rs1; ex_uses_rs1 = u1; ex_rs2 = rs2; ex_uses_rs2 = u2;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (fwd1_sel !== 2'd0) begin errors++; $display("FAIL reset_sel1: got %0d expected 0", fwd1_sel); end
        checks++; if (fwd2_sel !== 2'd0) begin errors++; $display("FAIL reset_sel2: got %0d expected 0", fwd2_sel); end
        checks++; if (opnd1 !== 32'h1111_0001) begin errors++; $display("FAIL reset_opnd1: got %h expected 11110001", opnd1); end
        checks++; if (opnd2 !== 32'h2222_0002) begin errors++; $display("FAIL reset_opnd2: got %h expected 22220002", opnd2); end
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", hazard_stall); end
    endtask

    task automatic test_alu_fwd;
        do_reset();
        ex_writer(5, 0);
        tick();
        ex_reader(5, 1, 6, 1);
        stage_wdata = {32'h1234_5678, 32'hDEAD_BEEF};
        #1;
        checks++; if (fwd1_sel !== 2'd1) begin errors++; $display("FAIL alu_sel1: got %0d expected 1", fwd1_sel); end
        checks++; if (opnd1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_opnd1: got %h expected deadbeef", opnd1); end
        checks++; if (fwd2_sel !== 2'd0) begin errors++; $display("FAIL alu_sel2: got %0d expected 0", fwd2_sel); end
        checks++; if (opnd2 !== 32'h2222_0002) begin errors++; $display("FAIL alu_opnd2: got %h expected 22220002", opnd2); end
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b expected 0", hazard_stall); end
    endtask

    task automatic test_youngest;
        do_reset();
        ex_writer(5, 0);
        tick();
        ex_writer(5, 0);
        tick();
        ex_reader(5, 1, 5, 1);
        stage_wdata = {32'h0000_0022, 32'h0000_0011};
        #1;
        checks++; if (fwd1_sel !== 2'd1) begin errors++; $display("FAIL young_sel1: got %0d expected 1", fwd1_sel); end
        checks++; if (fwd2_sel !== 2'd1) begin errors++; $display("FAIL young_sel2: got %0d expected 1", fwd2_sel); end
        checks++; if (opnd1 !== 32'h11) begin errors++; $display("FAIL young_opnd1: got %h expected 11", opnd1); end
        checks++; if (opnd2 !== 32'h11) begin errors++; $display("FAIL young_opnd2: got %h expected 11", opnd2); end
        tick();
        #1;
        checks++; if (fwd1_sel !== 2'd2) begin errors++; $display("FAIL older_sel1: got %0d expected 2", fwd1_sel); end
        checks++; if (opnd1 !== 32'h22) begin errors++; $display("FAIL older_opnd1: got %h expected 22", opnd1); end
    endtask

    task automatic test_load_use;
        do_reset();
        ex_writer(7, 1);
        tick();
        ex_reader(7, 1, 7, 1);
        #1;
        checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL lu_stall1: got %b expected 1", hazard_stall); end
        checks++; if (fwd1_sel !== 2'd1) begin errors++; $display("FAIL lu_sel1_stage1: got %0d expected 1", fwd1_sel); end
        tick();
        stage_wdata = {32'h00C0_FFEE, 32'h0};
        #1;
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_stall2: got %b expected 0", hazard_stall); end
        checks++; if (fwd1_sel !== 2'd2) begin errors++; $display("FAIL lu_sel1_stage2: got %0d expected 2", fwd1_sel); end
        checks++; if (fwd2_sel !== 2'd2) begin errors++; $display("FAIL lu_sel2_stage2: got %0d expected 2", fwd2_sel); end
        checks++; if (opnd1 !== 32'h00C0_FFEE) begin errors++; $display("FAIL lu_opnd1: got %h expected 00c0ffee", opnd1); end
        tick();
        #1;
        checks++; if (fwd1_sel !== 2'd0) begin errors++; $display("FAIL lu_retired_sel1: got %0d expected 0", fwd1_sel); end
        checks++; if (opnd1 !== 32'h1111_0001) begin errors++; $display("FAIL lu_retired_opnd1: got %h expected 11110001", opnd1); end
    endtask

    task automatic test_stall_in;
        int stall_cycles;
        do_reset();
        ex_writer(7, 1);
        tick();
        ex_reader(7, 1, 0, 0);
        stall_in = 1;
        stall_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) stall_in = 0;
            #1;
            if (hazard_stall === 1'b1) stall_cycles++;
            checks++; if (fwd1_sel !== 2'd1) begin errors++; $display("FAIL freeze_sel1_c%0d: got %0d expected 1", i, fwd1_sel); end
            tick();
        end
        checks++; if (stall_cycles !== 4) begin errors++; $display("FAIL freeze_stall_len: got %0d expected 4", stall_cycles); end
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL freeze_release: got %b expected 0", hazard_stall); end
        checks++; if (fwd1_sel !== 2'd2) begin errors++; $display("FAIL freeze_after_sel1: got %0d expected 2", fwd1_sel); end
    endtask

    task automatic test_x0_and_uses;
        do_reset();
        ex_writer(0, 0);
        tick();
        ex_reader(0, 1, 0, 1);
        rf_rs1 = 0; rf_rs2 = 0;
        stage_wdata = {32'h0, 32'h55};
        #1;
        checks++; if (fwd1_sel !== 2'd0) begin errors++; $display("FAIL x0_sel1: got %0d expected 0", fwd1_sel); end
        checks++; if (opnd1 !== 32'h0) begin errors++; $display("FAIL x0_opnd1: got %h expected 0", opnd1); end
        do_reset();
        ex_writer(9, 0);
        tick();
        ex_reader(9, 1, 9, 0);
        stage_wdata = {32'h0, 32'h99};
        #1;
        checks++; if (fwd2_sel !== 2'd0) begin errors++; $display("FAIL nouse_sel2: got %0d expected 0", fwd2_sel); end
        checks++; if (opnd2 !== 32'h2222_0002) begin errors++; $display("FAIL nouse_opnd2: got %h expected 22220002", opnd2); end
        checks++; if (fwd1_sel !== 2'd1) begin errors++; $display("FAIL nouse_sel1: got %0d expected 1", fwd1_sel); end
    endtask

    task automatic test_flush;
        do_reset();
        ex_writer(3, 1);
        flush = 1;
        tick();
        flush = 0;
        ex_reader(3, 1, 3, 1);
        #1;
        checks++; if (fwd1_sel !== 2'd0) begin errors++; $display("FAIL flush_sel1: got %0d expected 0", fwd1_sel); end
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", hazard_stall); end
        do_reset();
        ex_writer(3, 1);
        tick();
        ex_reader(3, 1, 0, 0);
        flush = 1;
        #1;
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL flush_mask_stall: got %b expected 0", hazard_stall); end
        checks++; if (fwd1_sel !== 2'd1) begin errors++; $display("FAIL flush_mask_sel1: got %0d expected 1", fwd1_sel); end
    endtask

    task automatic test_reset_mid_stall;
        do_reset();
        ex_writer(7, 1);
        tick();
        ex_reader(7, 1, 7, 1);
        stall_in = 1;
        #1;
        checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b expected 1", hazard_stall); end
        tick();
        rst = 1;
        tick();
        rst = 0;
        #1;
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b expected 0", hazard_stall); end
        checks++; if (fwd1_sel !== 2'd0) begin errors++; $display("FAIL rstmid_sel1: got %0d expected 0", fwd1_sel); end
        checks++; if (fwd2_sel !== 2'd0) begin errors++; $display("FAIL rstmid_sel2: got %0d expected 0", fwd2_sel); end
`ifdef FWD_HAZARD_PERF_EN
        checks++; if (perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_pstall: got %0d expected 0", perf_stall_cnt); end
        checks++; if (perf_fwd_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_pfwd: got %0d expected 0", perf_fwd_cnt); end
`endif
        stall_in = 0;
    endtask

`ifdef FWD_HAZARD_PERF_EN
    task automatic test_perf;
        do_reset();
        ex_writer(5, 0);
        tick();
        ex_reader(5, 1, 5, 1);
        tick();
        idle_inputs();
        #1;
        checks++; if (perf_fwd_cnt !== 32'd2) begin errors++; $display("FAIL perf_fwd: got %0d expected 2", perf_fwd_cnt); end
        ex_writer(7, 1);
        tick();
        ex_reader(7, 1, 0, 0);
        tick();
        #1;
        checks++; if (perf_stall_cnt !== 32'd1) begin errors++; $display("FAIL perf_stall: got %0d expected 1", perf_stall_cnt); end
    endtask
`endif

    initial begin
        rst = 0;
        idle_inputs();
        test_reset();
        test_alu_fwd();
        test_youngest();
        test_load_use();
        test_stall_in();
        test_x0_and_uses();
        test_flush();
        test_reset_mid_stall();
`ifdef FWD_HAZARD_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
